mem_bus_switch: RTL and testbench

- Parametrised successor to the hand-written iomem ready/rdata mux in the SoC top.
- Takes one picorv32 native memory bus (master side) and fans it out to NSLAVES slave ports, selected by per-slave base/mask address windows.
- Responses are registered.
- Adds features the flat mux lacks: a decode-error response for unmapped addresses, a per-access timeout watchdog, and sticky error capture (flag, address, count) for firmware diagnostics.

---
 rtl/mem_bus_switch.sv | 153 +++++++++++++++
 tb/tb_mem_bus_switch.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_switch.sv
// mem_bus_switch: picorv32 native bus fan-out to address-decoded slaves with registered responses, timeout and error capture
module mem_bus_switch #(
  parameter int NSLAVES = 4,
  parameter logic [NSLAVES*32-1:0] SLAVE_BASE = {32'h8000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0300_0000},
  parameter logic [NSLAVES*32-1:0] SLAVE_MASK = {32'h8000_0000, 32'hC000_0000, 32'hE000_0000, 32'hFFFF_FFFC},
  parameter int TIMEOUT = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   m_valid,
  input  logic [31:0]            m_addr,
  input  logic [31:0]            m_wdata,
  input  logic [3:0]             m_wstrb,
  output logic                   m_ready,
  output logic [31:0]            m_rdata,
  output logic [NSLAVES-1:0]     s_valid,
  output logic [31:0]            s_addr,
  output logic [31:0]            s_wdata,
  output logic [3:0]             s_wstrb,
  input  logic [NSLAVES-1:0]     s_ready,
  input  logic [NSLAVES*32-1:0]  s_rdata,
  input  logic                   err_clr,
  output logic                   err_flag,
  output logic                   err_timeout,
  output logic [31:0]            err_addr,
  output logic [7:0]             err_count
);
  localparam int SW = NSLAVES > 1 ? $clog2(NSLAVES) : 1;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_n;
  logic [SW-1:0] sel, sel_n, hit_idx;
  logic [TW-1:0] tcnt, tcnt_n;
  logic hit, sel_ready, ready_n, log_err, log_to;
  logic [31:0] sel_rdata, rdata_n, addr_n, wdata_n;
  logic [NSLAVES-1:0] valid_n;
  logic [3:0] wstrb_n;
  // address decode: scanning downward leaves the lowest matching index as winner
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NSLAVES - 1; i >= 0; i--)
      if ((m_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        hit = 1'b1;
        hit_idx = SW'(i);
      end
  end
  // response mux for the latched slave; other slaves' ready/rdata are ignored
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NSLAVES; i++)
      if (sel == SW'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[i*32 +: 32];
      end
  end
  // next state and next register values; everything holds unless a transition changes it
  always_comb begin
    state_n = state;
    sel_n = sel;
    tcnt_n = tcnt;
    ready_n = 1'b0;
    rdata_n = m_rdata;
    valid_n = s_valid;
    addr_n = s_addr;
    wdata_n = s_wdata;
    wstrb_n = s_wstrb;
    log_err = 1'b0;
    log_to = 1'b0;
    case (state)
      IDLE: if (m_valid && !m_ready) begin
        if (hit) begin
          state_n = BUSY;
          sel_n = hit_idx;
          tcnt_n = '0;
          valid_n = NSLAVES'(1) << hit_idx;
          addr_n = m_addr;
          wdata_n = m_wdata;
          wstrb_n = m_wstrb;
        end else begin
          state_n = RESP;
          ready_n = 1'b1;
          rdata_n = ERR_DATA;
          log_err = 1'b1;
        end
      end
      BUSY: if (sel_ready) begin
        state_n = RESP;
        valid_n = '0;
        ready_n = 1'b1;
        rdata_n = sel_rdata;
      end else if (tcnt == TW'(TIMEOUT - 1)) begin
        state_n = RESP;
        valid_n = '0;
        ready_n = 1'b1;
        rdata_n = ERR_DATA;
        log_err = 1'b1;
        log_to = 1'b1;
      end else if (!m_valid) begin
        state_n = IDLE;
        valid_n = '0;
      end else begin
        tcnt_n = tcnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  // transaction state and registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel <= '0;
      tcnt <= '0;
      m_ready <= 1'b0;
      m_rdata <= '0;
      s_valid <= '0;
      s_addr <= '0;
      s_wdata <= '0;
      s_wstrb <= '0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      tcnt <= tcnt_n;
      m_ready <= ready_n;
      m_rdata <= rdata_n;
      s_valid <= valid_n;
      s_addr <= addr_n;
      s_wdata <= wdata_n;
      s_wstrb <= wstrb_n;
    end
  end
  // sticky error capture; a new error overrides a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      err_flag <= 1'b0;
      err_timeout <= 1'b0;
      err_addr <= '0;
      err_count <= '0;
    end else if (log_err) begin
      err_flag <= 1'b1;
      err_timeout <= log_to;
      err_addr <= log_to ? s_addr : m_addr;
      err_count <= err_clr ? 8'd1 : (err_count == 8'hFF ? 8'hFF : err_count + 8'd1);
    end else if (err_clr) begin
      err_flag <= 1'b0;
      err_timeout <= 1'b0;
      err_addr <= '0;
      err_count <= '0;
    end
  end
endmodule

// File: tb/tb_mem_bus_switch.sv
// tb_mem_bus_switch: randomized transactions against a transaction-level model of the switch
module tb_mem_bus_switch;
  localparam int NS = 4;
  localparam int TO = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  localparam logic [NS*32-1:0] BASE = {32'h8000_0000, 32'h4000_0000, 32'h4000_0000, 32'h0300_0000};
  localparam logic [NS*32-1:0] MASK = {32'h8000_0000, 32'hC000_0000, 32'hF000_0000, 32'hFFFF_FFFC};
  logic clk, reset, m_valid, m_ready, err_clr, err_flag, err_timeout;
  logic [31:0] m_addr, m_wdata, m_rdata, s_addr, s_wdata, err_addr;
  logic [3:0] m_wstrb, s_wstrb;
  logic [NS-1:0] s_valid, s_ready;
  logic [NS*32-1:0] s_rdata;
  logic [7:0] err_count;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_last, e_addr;
  logic e_flag, e_to;
  int e_cnt;

  mem_bus_switch #(.NSLAVES(NS), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata), .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata), .err_clr(err_clr), .err_flag(err_flag),
    .err_timeout(err_timeout), .err_addr(err_addr), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // windows above resolved by hand, with slave 1 shadowing slave 2 over 0x4xxx_xxxx
  function automatic int ref_sel(input logic [31:0] a);
    if (a >= 32'h8000_0000) return 3;
    if (a[31:28] == 4'h4) return 1;
    if (a >= 32'h5000_0000) return 2;
    if (a >= 32'h0300_0000 && a <= 32'h0300_0003) return 0;
    return -1;
  endfunction

  function automatic logic [31:0] gen_addr(input int r);
    case (r)
      0: return 32'h0300_0000 + 32'($urandom_range(0, 3));
      1: return {4'h4, 28'($urandom)};
      2: return 32'h5000_0000 + ($urandom % 32'h3000_0000);
      3: return 32'h8000_0000 | 32'($urandom);
      default: return $urandom_range(0, 1) ? ($urandom % 32'h0300_0000) : 32'h0300_0004 + ($urandom % 32'h3CFF_FFFC);
    endcase
  endfunction

  task automatic m_log(input logic [31:0] a, input logic to, input bit clr);
    e_flag = 1'b1;
    e_to = to;
    e_addr = a;
    e_cnt = clr ? 1 : (e_cnt < 255 ? e_cnt + 1 : 255);
  endtask

  task automatic m_clear();
    e_flag = 1'b0;
    e_to = 1'b0;
    e_addr = '0;
    e_cnt = 0;
  endtask

  task automatic chk_err();
    chk("err_flag", 32'(err_flag), 32'(e_flag));
    chk("err_timeout", 32'(err_timeout), 32'(e_to));
    chk("err_addr", err_addr, e_addr);
    chk("err_count", 32'(err_count), 32'(e_cnt));
  endtask

  // one master access; called at a negedge with the switch idle, returns at a negedge with it idle
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, input int d, input int ab_in, input bit clr);
    int es, ab, ke, kv, last;
    logic [3:0] oh;
    logic [31:0] rd, resp;
    es = ref_sel(a);
    ab = (es < 0 || ab_in > d || ab_in > TO - 1) ? 0 : ab_in;
    oh = (es < 0) ? 4'b0 : 4'(1 << es);
    for (int i = 0; i < NS; i++) s_rdata[i*32 +: 32] = $urandom;
    rd = (es < 0) ? 32'h0 : s_rdata[es*32 +: 32];
    if (es < 0) begin ke = 1; kv = 0; resp = ERR; end
    else if (ab > 0) begin ke = 0; kv = ab; resp = m_last; end
    else if (d <= TO - 1) begin ke = d + 2; kv = d + 1; resp = rd; end
    else begin ke = TO + 1; kv = TO; resp = ERR; end
    last = (ke == 0) ? ab + 2 : ke + 1;
    m_valid = 1'b1;
    m_addr = a;
    m_wdata = wd;
    m_wstrb = ws;
    err_clr = clr;
    s_ready = '0;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      err_clr = 1'b0;
      if (k == 1) begin
        if (es < 0) m_log(a, 1'b0, clr);
        else if (clr) m_clear();
      end
      if (k == ke) begin
        if (es >= 0 && ab == 0 && d > TO - 1) m_log(a, 1'b1, 1'b0);
        m_last = resp;
      end
      chk("s_valid", 32'(s_valid), 32'(k <= kv ? oh : 4'b0));
      chk("m_ready", 32'(m_ready), 32'(k == ke));
      chk("m_rdata", m_rdata, m_last);
      if (k <= kv) begin
        chk("s_addr", s_addr, a);
        chk("s_wdata", s_wdata, wd);
        chk("s_wstrb", 32'(s_wstrb), 32'(ws));
      end
      chk_err();
      if (k == ke || k == ab) m_valid = 1'b0;
      s_ready = 4'($urandom) & ~oh;
      if (es >= 0 && k == d + 1) s_ready = s_ready | oh;
    end
    m_valid = 1'b0;
    s_ready = '0;
  endtask

  task automatic gap(input int n);
    for (int g = 0; g < n; g++) begin
      @(negedge clk);
      chk("idle_s_valid", 32'(s_valid), 32'h0);
      chk("idle_m_ready", 32'(m_ready), 32'h0);
    end
  endtask

  initial begin
    reset = 1'b1;
    m_valid = 1'b0;
    m_addr = '0;
    m_wdata = '0;
    m_wstrb = '0;
    s_ready = '0;
    s_rdata = '0;
    err_clr = 1'b0;
    m_last = '0;
    m_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_ready", 32'(m_ready), 32'h0);
    chk("rst_m_rdata", m_rdata, 32'h0);
    chk("rst_s_valid", 32'(s_valid), 32'h0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_s_wdata", s_wdata, 32'h0);
    chk("rst_s_wstrb", 32'(s_wstrb), 32'h0);
    chk_err();
    reset = 1'b0;
    gap(1);
    txn(32'h0300_0000, 32'h0, 4'h0, 0, 0, 1'b0);
    txn(32'h8000_0010, 32'h1234_5678, 4'hF, 5, 0, 1'b0);
    txn(32'h0100_0000, 32'h0, 4'h0, 0, 0, 1'b0);
    txn(32'h4000_0000, 32'h0, 4'h0, 50, 0, 1'b0);
    txn(32'h5000_0000, 32'hA5A5_0000, 4'h3, 1, 0, 1'b0);
    txn(32'h4800_0000, 32'h0, 4'h0, 7, 0, 1'b0);
    txn(32'h9000_0000, 32'h0, 4'h0, 9, 3, 1'b0);
    txn(32'h2000_0000, 32'h0, 4'h0, 0, 0, 1'b1);
    txn(32'h7000_0000, 32'h0, 4'h0, 2, 0, 1'b1);
    for (int n = 0; n < 300; n++) begin
      txn(gen_addr($urandom_range(0, 4)), $urandom, 4'($urandom), $urandom_range(0, 10),
          $urandom_range(0, 3) == 0 ? $urandom_range(1, 7) : 0, $urandom_range(0, 15) == 0);
      gap($urandom_range(0, 2));
    end
    for (int n = 0; n < 300; n++) txn(gen_addr(4), 32'h0, 4'h0, 0, 0, 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_clear();
    chk_err();
    txn(32'h0000_0040, 32'h0, 4'h0, 0, 0, 1'b0);
    m_valid = 1'b1;
    m_addr = 32'h9000_0000;
    s_ready = '0;
    repeat (3) @(negedge clk);
    chk("stall_s_valid", 32'(s_valid), 32'h8);
    reset = 1'b1;
    @(negedge clk);
    m_last = '0;
    m_clear();
    chk("rstb_s_valid", 32'(s_valid), 32'h0);
    chk("rstb_m_ready", 32'(m_ready), 32'h0);
    chk("rstb_m_rdata", m_rdata, 32'h0);
    chk_err();
    reset = 1'b0;
    m_valid = 1'b0;
    gap(1);
    txn(32'h0300_0002, 32'h0, 4'h0, 0, 0, 1'b0);
    gap(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
